// File: rtl/reverse_bits.sv
// reverse_bits: mirrors the bit order of two independent WIDTH-bit operands.
//
// q and w are the combinational mirrors of a and b. They do not depend on
// clk, rst or en, so they stay valid during reset. q_r and w_r are copies
// registered on en, and vld strobes for one cycle after each capture.
//
// Build option: define REVERSE_BITS_PALINDROME_EN to add the palindrome
// flags pal_a/pal_b and their registered copies pal_a_r/pal_b_r.
//
// Ports:
//   clk     rising-edge clock
//   rst     synchronous reset, active-high, has priority over en
//   en      capture enable for the registered results
//   a, b    operands
//   q, w    combinational bit-reverse of a, b
//   q_r,w_r registered bit-reverse of a, b (1-cycle latency)
//   vld     high for one cycle after a capture
//   pal_a, pal_b, pal_a_r, pal_b_r  (optional) operand equals its own reverse
module reverse_bits #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] w,
  output logic [WIDTH-1:0] q_r,
  output logic [WIDTH-1:0] w_r,
`ifdef REVERSE_BITS_PALINDROME_EN
  output logic             pal_a,
  output logic             pal_b,
  output logic             pal_a_r,
  output logic             pal_b_r,
`endif
  output logic             vld
);

  // Pure rewiring: each output bit is taken from the mirrored input bit, so
  // an X on an input bit appears only on the mirrored output bit.
  function automatic logic [WIDTH-1:0] reverse(input logic [WIDTH-1:0] x);
    logic [WIDTH-1:0] r;
    for (int i = 0; i < WIDTH; i++) begin
      r[i] = x[WIDTH-1-i];
    end
    return r;
  endfunction

  assign q = reverse(a);
  assign w = reverse(b);

  always_ff @(posedge clk) begin
    if (rst) begin
      q_r <= '0;
      w_r <= '0;
      vld <= 1'b0;
    end else if (en) begin
      q_r <= q;
      w_r <= w;
      vld <= 1'b1;
    end else begin
      vld <= 1'b0;
    end
  end

`ifdef REVERSE_BITS_PALINDROME_EN
  assign pal_a = (a == q);
  assign pal_b = (b == w);

  always_ff @(posedge clk) begin
    if (rst) begin
      pal_a_r <= 1'b0;
      pal_b_r <= 1'b0;
    end else if (en) begin
      pal_a_r <= pal_a;
      pal_b_r <= pal_b;
    end
  end
`endif

endmodule

// File: tb/tb_reverse_bits.sv
module tb_reverse_bits;

  localparam int WIDTH = 8;

  logic             clk;
  logic             rst;
  logic             en;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] w;
  logic [WIDTH-1:0] q_r;
  logic [WIDTH-1:0] w_r;
  logic             vld;
`ifdef REVERSE_BITS_PALINDROME_EN
  logic             pal_a;
  logic             pal_b;
  logic             pal_a_r;
  logic             pal_b_r;
`endif

  reverse_bits #(.WIDTH(WIDTH)) dut (
    .clk    (clk),
    .rst    (rst),
    .en     (en),
    .a      (a),
    .b      (b),
    .q      (q),
    .w      (w),
    .q_r    (q_r),
    .w_r    (w_r),
`ifdef REVERSE_BITS_PALINDROME_EN
    .pal_a  (pal_a),
    .pal_b  (pal_b),
    .pal_a_r(pal_a_r),
    .pal_b_r(pal_b_r),
`endif
    .vld    (vld)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] w;
    logic             pa;
    logic             pb;
  } exp_t;

  exp_t exp_q[$];
  exp_t cur;
  exp_t held;

  int errors = 0;
  int checks = 0;

  // Reference reverse written with the streaming operator.
  function automatic logic [WIDTH-1:0] ref_rev(input logic [WIDTH-1:0] x);
    logic [WIDTH-1:0] r;
    r = {<<{x}};
    return r;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv);
    a = av;
    b = bv;
    #1;
    check("comb_q", q, ref_rev(av));
    check("comb_w", w, ref_rev(bv));
  endtask

  // Push the expected registered result, clock it in, pop and compare.
  task automatic capture_cycle(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv);
    en = 1'b1;
    drive(av, bv);
    exp_q.push_back('{q: ref_rev(av), w: ref_rev(bv),
                      pa: (av == ref_rev(av)), pb: (bv == ref_rev(bv))});
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL scoreboard_empty observed=0 expected=1");
    end else begin
      cur = exp_q.pop_front();
      check("reg_q_r", q_r, cur.q);
      check("reg_w_r", w_r, cur.w);
      check("reg_vld", vld, 1);
`ifdef REVERSE_BITS_PALINDROME_EN
      check("reg_pal_a_r", pal_a_r, cur.pa);
      check("reg_pal_b_r", pal_b_r, cur.pb);
`endif
      held = cur;
    end
  endtask

  initial begin
    rst = 1'b1;
    en  = 1'b0;
    a   = '0;
    b   = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_q_r", q_r, 0);
    check("rst_w_r", w_r, 0);
    check("rst_vld", vld, 0);

    // Combinational path, still in reset: no edge needed.
    a = 8'h01; b = 8'h0F; #1;
    check("comb_01", q, 8'h80);
    check("comb_0F", w, 8'hF0);
    a = 8'hD2; b = 8'hA5; #1;
    check("comb_D2", q, 8'h4B);
    check("comb_A5", w, 8'hA5);
`ifdef REVERSE_BITS_PALINDROME_EN
    check("pal_a_D2", pal_a, 0);
    check("pal_b_A5", pal_b, 1);
`endif

    // Registered capture then hold.
    @(posedge clk); #1;
    rst = 1'b0;
    capture_cycle(8'h01, 8'hFF);
    check("cap_q_r_80", q_r, 8'h80);
    en = 1'b0;
    drive(8'h5A, 8'h12);
    @(posedge clk); #1;
    check("hold_q_r", q_r, held.q);
    check("hold_w_r", w_r, held.w);
    check("hold_vld", vld, 0);

    // Boundaries: all zeros, all ones, palindromes.
    capture_cycle(8'h00, 8'hFF);
    capture_cycle(8'hFF, 8'h00);
    capture_cycle(8'hA5, 8'h81);

    // Reset has priority over en; comb path keeps tracking.
    rst = 1'b1;
    en  = 1'b1;
    a = 8'h3C; b = 8'hC8; #1;
    check("rstpri_comb_q", q, 8'h3C);
    check("rstpri_comb_w", w, 8'h13);
    @(posedge clk); #1;
    check("rstpri_q_r", q_r, 0);
    check("rstpri_w_r", w_r, 0);
    check("rstpri_vld", vld, 0);
    rst = 1'b0;

    // Random sweep with en held high; vld should stay high throughout.
    for (int i = 0; i < 12; i++) begin
      capture_cycle(WIDTH'($urandom), WIDTH'($urandom));
    end

    // Mid-stream reset clears on that edge, then first capture follows.
    rst = 1'b1;
    drive(8'hE1, 8'h37);
    @(posedge clk); #1;
    check("mid_rst_q_r", q_r, 0);
    check("mid_rst_vld", vld, 0);
    rst = 1'b0;
    capture_cycle(8'hE1, 8'h37);

    check("scoreboard_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
